// File: rtl/watchdog_controller.sv
// Watchdog link to a remote reset manager: toggles a watchdog line, checks its
// echo and an alive heartbeat, and drives trigger / instant-reset lines.
module watchdog_controller #(
  parameter int WATCHDOG_HALF_PERIOD = 1250000,
  parameter int ACK_TIMEOUT          = 1000,
  parameter int ALIVE_TIMEOUT        = 15625000,
  parameter int INSTANT_RESET_CYCLES = 125
) (
  input  logic        clk,
  input  logic        peripheral_reset,
  input  logic [7:0]  ctrl_cfg,
  input  logic        reset_ack_in,
  input  logic        alive_signal_in,
  output logic        watchdog_out,
  output logic        trigger_out,
  output logic        instant_reset_out,
  output logic [31:0] ctrl_sts
);

  localparam int HW  = $clog2(WATCHDOG_HALF_PERIOD + 1);
  localparam int KW  = $clog2(ACK_TIMEOUT + 1);
  localparam int AW  = $clog2(ALIVE_TIMEOUT + 1);
  localparam int PW  = $clog2(INSTANT_RESET_CYCLES + 1);

  localparam logic [HW-1:0] HALF_LAST  = HW'(WATCHDOG_HALF_PERIOD - 1);
  localparam logic [KW-1:0] ACK_LAST   = KW'(ACK_TIMEOUT - 1);
  localparam logic [AW-1:0] ALIVE_LAST = AW'(ALIVE_TIMEOUT - 1);
  localparam logic [AW-1:0] ALIVE_MAX  = AW'(ALIVE_TIMEOUT);
  localparam logic [PW-1:0] PULSE_LEN  = PW'(INSTANT_RESET_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t        state_q;
  logic          wd_q;
  logic          ack_fault_q;
  logic          alive_fault_q;
  logic          trig_q;
  logic          ack_s1_q, ack_s2_q;
  logic          alive_s1_q, alive_s2_q, alive_prev_q;
  logic          clr_prev_q, man_prev_q;
  logic [HW-1:0] half_cnt_q;
  logic [KW-1:0] ack_cnt_q;
  logic          ack_act_q;
  logic [AW-1:0] alive_cnt_q;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;

  logic clr_edge, man_edge, alive_rise, ack_match, half_tc, ack_to, alive_to;
  logic inst_w, trig_w;
  logic unused_cfg;

  assign unused_cfg = ^ctrl_cfg[7:5];

  assign clr_edge   = ctrl_cfg[3] & ~clr_prev_q;
  assign man_edge   = ctrl_cfg[4] & ~man_prev_q;
  assign alive_rise = alive_s2_q & ~alive_prev_q;
  assign ack_match  = (ack_s2_q == wd_q);
  assign half_tc    = (half_cnt_q == HALF_LAST);
  assign ack_to     = ack_act_q & ~ack_match & (ack_cnt_q == ACK_LAST);
  assign alive_to   = ~alive_rise & (alive_cnt_q == ALIVE_LAST);

  // A new manual edge reloads the pulse, so an overlapping request stretches it.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (man_edge)
      pulse_cnt_d = PULSE_LEN;
    else if (pulse_cnt_q != '0)
      pulse_cnt_d = pulse_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (peripheral_reset) begin
      state_q       <= ST_IDLE;
      wd_q          <= 1'b0;
      ack_fault_q   <= 1'b0;
      alive_fault_q <= 1'b0;
      trig_q        <= 1'b0;
      ack_s1_q      <= 1'b0;
      ack_s2_q      <= 1'b0;
      alive_s1_q    <= 1'b0;
      alive_s2_q    <= 1'b0;
      alive_prev_q  <= 1'b0;
      clr_prev_q    <= 1'b0;
      man_prev_q    <= 1'b0;
      half_cnt_q    <= '0;
      ack_cnt_q     <= '0;
      ack_act_q     <= 1'b0;
      alive_cnt_q   <= '0;
      pulse_cnt_q   <= '0;
    end else begin
      ack_s1_q     <= reset_ack_in;
      ack_s2_q     <= ack_s1_q;
      alive_s1_q   <= alive_signal_in;
      alive_s2_q   <= alive_s1_q;
      alive_prev_q <= alive_s2_q;
      clr_prev_q   <= ctrl_cfg[3];
      man_prev_q   <= ctrl_cfg[4];
      trig_q       <= ctrl_cfg[1];
      pulse_cnt_q  <= pulse_cnt_d;

      case (state_q)
        ST_IDLE: begin
          wd_q        <= 1'b0;
          half_cnt_q  <= '0;
          ack_cnt_q   <= '0;
          ack_act_q   <= 1'b0;
          alive_cnt_q <= '0;
          if (ctrl_cfg[0]) state_q <= ST_RUN;
        end

        ST_RUN: begin
          if (!ctrl_cfg[0]) begin
            state_q     <= ST_IDLE;
            wd_q        <= 1'b0;
            half_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            ack_act_q   <= 1'b0;
            alive_cnt_q <= '0;
          end else if (ack_to || alive_to) begin
            // Counters and watchdog freeze here; the remote sees the line stop.
            state_q <= ST_FAULT;
            if (ack_to)   ack_fault_q   <= 1'b1;
            if (alive_to) alive_fault_q <= 1'b1;
          end else begin
            if (alive_rise)
              alive_cnt_q <= '0;
            else if (alive_cnt_q != ALIVE_MAX)
              alive_cnt_q <= alive_cnt_q + 1'b1;

            if (half_tc) begin
              half_cnt_q <= '0;
              wd_q       <= ~wd_q;
              ack_act_q  <= 1'b1;
              ack_cnt_q  <= '0;
            end else begin
              half_cnt_q <= half_cnt_q + 1'b1;
              if (ack_act_q) begin
                if (ack_match) ack_act_q <= 1'b0;
                else           ack_cnt_q <= ack_cnt_q + 1'b1;
              end
            end
          end
        end

        ST_FAULT: begin
          if (clr_edge) begin
            ack_fault_q   <= 1'b0;
            alive_fault_q <= 1'b0;
            half_cnt_q    <= '0;
            ack_cnt_q     <= '0;
            ack_act_q     <= 1'b0;
            alive_cnt_q   <= '0;
            if (ctrl_cfg[0]) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_IDLE;
              wd_q    <= 1'b0;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign inst_w = (pulse_cnt_q != '0) | ((state_q == ST_FAULT) & ctrl_cfg[2]);
  assign trig_w = trig_q & (state_q == ST_RUN) & ~inst_w;

  assign watchdog_out      = wd_q;
  assign instant_reset_out = inst_w;
  assign trigger_out       = trig_w;
  assign ctrl_sts = {23'd0, trig_w, inst_w, alive_s2_q, ack_s2_q, wd_q,
                     alive_fault_q, ack_fault_q, state_q};

endmodule

// File: tb/tb_watchdog_controller.sv
// Bench for watchdog_controller: directed scenarios plus a random phase, all
// compared each cycle against a cycle-timestamp reference model.
module tb_watchdog_controller;

  localparam int HALF  = 8;
  localparam int ACKT  = 4;
  localparam int ALIVE = 40;
  localparam int IRC   = 5;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg;
  logic        ack_net;
  logic        alive_in;
  logic        watchdog_out, trigger_out, instant_reset_out;
  logic [31:0] ctrl_sts;

  logic loop_ack, ack_force;
  int   alive_per, acnt;
  int   checks, errors;

  assign ack_net = loop_ack ? watchdog_out : ack_force;

  watchdog_controller #(
    .WATCHDOG_HALF_PERIOD(HALF),
    .ACK_TIMEOUT(ACKT),
    .ALIVE_TIMEOUT(ALIVE),
    .INSTANT_RESET_CYCLES(IRC)
  ) dut (
    .clk(clk),
    .peripheral_reset(rst),
    .ctrl_cfg(cfg),
    .reset_ack_in(ack_net),
    .alive_signal_in(alive_in),
    .watchdog_out(watchdog_out),
    .trigger_out(trigger_out),
    .instant_reset_out(instant_reset_out),
    .ctrl_sts(ctrl_sts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: deadlines expressed as absolute edge numbers.
  int m_cyc, m_state, run_start, last_alive, ack_deadline, pulse_until;
  bit m_wd, m_ackf, m_alivef, m_trig, m_pend, p3, p4;
  bit ack1, ack2, al1, al2, al3;

  always @(posedge clk) begin
    bit ack_raw, clr, man, rise, f_ack, f_al;
    m_cyc++;
    if (rst) begin
      m_state = 0; m_wd = 0; m_ackf = 0; m_alivef = 0; m_trig = 0; m_pend = 0;
      p3 = 0; p4 = 0; ack1 = 0; ack2 = 0; al1 = 0; al2 = 0; al3 = 0;
      pulse_until = 0;
    end else begin
      ack_raw = loop_ack ? m_wd : ack_force;
      clr  = cfg[3] && !p3;
      man  = cfg[4] && !p4;
      rise = al2 && !al3;
      case (m_state)
        0: begin
          m_wd = 0;
          if (cfg[0]) begin
            m_state = 1; run_start = m_cyc; last_alive = m_cyc; m_pend = 0;
          end
        end
        1: begin
          if (!cfg[0]) begin
            m_state = 0; m_wd = 0; m_pend = 0;
          end else begin
            f_ack = m_pend && (ack2 != m_wd) && (m_cyc == ack_deadline);
            f_al  = !rise && (m_cyc - last_alive == ALIVE);
            if (rise) last_alive = m_cyc;
            if (m_pend && ack2 == m_wd) m_pend = 0;
            if (f_ack || f_al) begin
              m_state = 2;
              if (f_ack) m_ackf = 1;
              if (f_al)  m_alivef = 1;
            end else if ((m_cyc - run_start) % HALF == 0) begin
              m_wd = !m_wd; m_pend = 1; ack_deadline = m_cyc + ACKT;
            end
          end
        end
        default: begin
          if (clr) begin
            m_ackf = 0; m_alivef = 0; m_pend = 0;
            if (cfg[0]) begin
              m_state = 1; run_start = m_cyc; last_alive = m_cyc;
            end else begin
              m_state = 0; m_wd = 0;
            end
          end
        end
      endcase
      if (man) pulse_until = m_cyc + IRC;
      m_trig = cfg[1];
      p3 = cfg[3]; p4 = cfg[4];
      al3 = al2; al2 = al1; al1 = alive_in;
      ack2 = ack1; ack1 = ack_raw;
    end
  end

  function automatic bit exp_inst();
    return (m_cyc < pulse_until) || (m_state == 2 && cfg[2]);
  endfunction

  function automatic bit exp_trig();
    return m_trig && (m_state == 1) && !exp_inst();
  endfunction

  function automatic logic [31:0] exp_sts();
    logic [1:0] st;
    st = 2'(m_state);
    return {23'd0, exp_trig(), exp_inst(), al2, ack2, m_wd, m_alivef, m_ackf, st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model_sts", ctrl_sts, exp_sts());
    chk("model_outs", {29'd0, watchdog_out, trigger_out, instant_reset_out},
        {29'd0, m_wd, exp_trig(), exp_inst()});
    if (alive_per > 0) begin
      alive_in = (acnt % alive_per) < (alive_per / 2);
      acnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg = 8'h00;
    tick();
    chk("reset_sts", ctrl_sts, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_wd(input logic val, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (watchdog_out === val) begin
        ok = 1;
        break;
      end
    end
    chk("wd_wait", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int hi, tr, last_t;
    bit seen;
    logic last_wd;
    checks = 0; errors = 0; m_cyc = 0; pulse_until = 0;
    rst = 1'b1; cfg = 8'h00; loop_ack = 1'b1; ack_force = 1'b0;
    alive_in = 1'b0; alive_per = 0; acnt = 0;
    tick();
    tick();
    chk("reset_init", ctrl_sts, 32'd0);
    rst = 1'b0;

    // Healthy link: looped ack, heartbeat every 20 cycles.
    alive_per = 20; acnt = 0; cfg = 8'h01;
    seen = 0; last_t = 0; last_wd = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk("run_state", {28'd0, ctrl_sts[3:0]}, 32'h1);
      if (watchdog_out !== last_wd) begin
        if (seen) chk("wd_period", i - last_t, HALF);
        seen = 1; last_t = i; last_wd = watchdog_out;
      end
    end

    // Ack tied low: fault exactly ACKT cycles after the first rising toggle.
    do_reset();
    loop_ack = 1'b0; ack_force = 1'b0; cfg = 8'h01;
    wait_wd(1'b1, 20);
    repeat (3) tick();
    chk("ack_pre_fault", {30'd0, ctrl_sts[1:0]}, 32'd1);
    tick();
    chk("ack_fault_state", {30'd0, ctrl_sts[1:0]}, 32'd2);
    chk("ack_fault_flag", {31'd0, ctrl_sts[2]}, 32'd1);
    repeat (20) tick();
    chk("wd_frozen", {31'd0, watchdog_out}, 32'd1);

    // Clear edge coinciding with an ack timeout: the fault wins.
    do_reset();
    cfg = 8'h01;
    wait_wd(1'b1, 20);
    repeat (3) tick();
    cfg = 8'h09;
    tick();
    chk("clr_vs_fault_state", {30'd0, ctrl_sts[1:0]}, 32'd2);
    chk("clr_vs_fault_flag", {31'd0, ctrl_sts[2]}, 32'd1);
    cfg = 8'h01;
    tick();
    cfg = 8'h09;
    tick();
    chk("clr_to_run", {28'd0, ctrl_sts[3:0]}, 32'h1);
    cfg = 8'h00;
    tick();
    chk("disable_idle", {30'd0, ctrl_sts[1:0]}, 32'd0);

    // Alive held low with auto instant reset: fault on the 40th RUN cycle.
    do_reset();
    loop_ack = 1'b1; alive_per = 0; alive_in = 1'b0; cfg = 8'h05;
    tick();
    chk("alive_run", {30'd0, ctrl_sts[1:0]}, 32'd1);
    repeat (39) tick();
    chk("alive_pre_fault", {30'd0, ctrl_sts[1:0]}, 32'd1);
    tick();
    chk("alive_fault", {28'd0, ctrl_sts[3:0]}, 32'h a);
    chk("alive_inst", {31'd0, instant_reset_out}, 32'd1);
    repeat (5) tick();
    chk("alive_inst_hold", {31'd0, instant_reset_out}, 32'd1);
    cfg = 8'h0D;
    tick();
    chk("alive_clear", {28'd0, ctrl_sts[3:0]}, 32'h1);
    chk("alive_clear_inst", {31'd0, instant_reset_out}, 32'd0);
    cfg = 8'h00;
    tick();

    // Manual pulses in IDLE: second edge three cycles later stretches to 8.
    do_reset();
    alive_per = 20; cfg = 8'h02;
    tick();
    hi = 0; tr = 0;
    cfg = 8'h12; tick(); hi += instant_reset_out; tr += trigger_out;
    cfg = 8'h02; tick(); hi += instant_reset_out; tr += trigger_out;
    tick(); hi += instant_reset_out; tr += trigger_out;
    cfg = 8'h12;
    repeat (12) begin
      tick(); hi += instant_reset_out; tr += trigger_out;
    end
    chk("pulse_len", hi, 8);
    chk("pulse_trig", tr, 0);
    cfg = 8'h03;
    tick();
    chk("trig_run", {31'd0, trigger_out}, 32'd1);
    cfg = 8'h13;
    tick();
    chk("trig_masked", {30'd0, trigger_out, instant_reset_out}, 32'd1);
    cfg = 8'h03;
    repeat (6) tick();
    chk("trig_back", {31'd0, trigger_out}, 32'd1);
    cfg = 8'h01;
    tick();
    chk("trig_off", {31'd0, trigger_out}, 32'd0);

    // Reset while faulted with instant reset and a manual pulse active.
    do_reset();
    loop_ack = 1'b0; ack_force = 1'b0; cfg = 8'h05;
    wait_wd(1'b1, 20);
    repeat (4) tick();
    chk("pre_rst_fault", {30'd0, ctrl_sts[1:0]}, 32'd2);
    chk("pre_rst_inst", {31'd0, instant_reset_out}, 32'd1);
    cfg = 8'h15;
    tick();
    rst = 1'b1; cfg = 8'h05;
    tick();
    chk("rst_abort_sts", ctrl_sts, 32'd0);
    chk("rst_abort_outs", {29'd0, watchdog_out, trigger_out, instant_reset_out}, 32'd0);
    rst = 1'b0; cfg = 8'h04;
    hi = 0;
    repeat (10) begin
      tick(); hi += instant_reset_out;
    end
    chk("no_residual_pulse", hi, 0);

    // Random traffic against the model.
    loop_ack = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg = 8'($urandom);
        cfg[0] = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 49) == 0) loop_ack = ~loop_ack;
      ack_force = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        alive_per = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(6, 30);
        alive_in = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watchdog_controller.md
WATCHDOG_CONTROLLER -- requirements
Module: watchdog_controller

Interface
REQ-001 SHALL have parameter WATCHDOG_HALF_PERIOD, default 1250000: clk cycles between watchdog_out toggles (10 ms at 125 MHz).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1000: maximum cycles from a watchdog_out toggle to a matching synced reset_ack_in.
REQ-003 SHALL have parameter ALIVE_TIMEOUT, default 15625000: maximum cycles between synced alive_signal_in rising edges.
REQ-004 SHALL have parameter INSTANT_RESET_CYCLES, default 125: width of a manual instant_reset_out pulse.
REQ-005 SHALL have port clk, input, 1: the only clock; all logic on posedge.
REQ-006 SHALL have port peripheral_reset, input, 1: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port ctrl_cfg, input, 8: bit0 enable, bit1 trigger request, bit2 auto instant reset on fault, bit3 fault clear (rising edge), bit4 manual instant reset (rising edge), bits7:5 ignored.
REQ-008 SHALL have port reset_ack_in, input, 1: asynchronous echo of watchdog from the remote reset manager.
REQ-009 SHALL have port alive_signal_in, input, 1: asynchronous alive heartbeat from the remote reset manager.
REQ-010 SHALL have port watchdog_out, output, 1: toggling watchdog to the remote.
REQ-011 SHALL have port trigger_out, output, 1: trigger to the remote.
REQ-012 SHALL have port instant_reset_out, output, 1: instant reset to the remote.
REQ-013 SHALL have port ctrl_sts, output, 32: status word.

Function
REQ-014 SHALL pass reset_ack_in and alive_signal_in through 2-FF synchronizers; all checks use synced values (2-cycle latency).
REQ-015 SHALL latch ctrl_cfg bit3/bit4 previous values for rising-edge detection; edge active the cycle after the bit goes 0->1.
REQ-016 SHALL implement FSM states IDLE, RUN, FAULT.
REQ-017 IDLE: watchdog_out 0, all counters 0; enable=1 -> RUN next cycle.
REQ-018 RUN: half-period counter 0..WATCHDOG_HALF_PERIOD-1; at terminal count, watchdog_out toggles and counter wraps to 0.
REQ-019 RUN: each toggle starts ack counter; synced ack equal to watchdog_out stops it; reaching ACK_TIMEOUT with mismatch sets sticky ack_fault and enters FAULT.
REQ-020 RUN: alive counter clears on synced alive rising edge, else increments, saturating; reaching ALIVE_TIMEOUT sets sticky alive_fault and enters FAULT.
REQ-021 RUN with enable=0 -> IDLE next cycle; watchdog_out forced 0; faults unaffected.
REQ-022 FAULT: watchdog_out frozen (remote times out), trigger_out 0; instant_reset_out held 1 while bit2=1; enable ignored.
REQ-023 FAULT + clear edge -> RUN (enable=1) or IDLE (enable=0), counters zeroed, both fault flags cleared.
REQ-024 Clear edge coinciding with a new fault detection: fault wins, state FAULT, flag set.
REQ-025 trigger_out = registered bit1 (1-cycle latency), forced 0 when state!=RUN or instant_reset_out=1.
REQ-026 Manual edge: instant_reset_out 1 for exactly INSTANT_RESET_CYCLES cycles in any state; new edge mid-pulse restarts count.
REQ-027 instant_reset_out = manual pulse OR (FAULT AND bit2).
REQ-028 ctrl_sts: [1:0] state (IDLE=0, RUN=1, FAULT=2), [2] ack_fault, [3] alive_fault, [4] watchdog_out, [5] synced ack, [6] synced alive, [7] instant_reset_out, [8] trigger_out, [31:9] 0.

Reset
REQ-029 peripheral_reset=1 SHALL force on next edge: state IDLE, watchdog_out 0, trigger_out 0, instant_reset_out 0, faults 0, counters 0, synchronizers and edge registers 0, ctrl_sts 0.
REQ-030 Reset mid-pulse or in FAULT SHALL abort immediately; no residual pulse after release.

Verification (HALF=8, ACK_TIMEOUT=4, ALIVE_TIMEOUT=40, INSTANT_RESET_CYCLES=5)
REQ-031 enable=1, reset_ack_in looped from watchdog_out, alive edge every 20 cycles -> watchdog_out toggles every 8 cycles, ctrl_sts[3:0]=0x1 for 1000 cycles.
REQ-032 reset_ack_in tied 0 -> first 0->1 toggle, 4 cycles later state FAULT, ctrl_sts[2]=1, watchdog_out frozen at 1.
REQ-033 alive held 0, ack looped, bit2=1 -> cycle 40 FAULT, alive_fault=1, instant_reset_out=1 until bit3 edge, then RUN, flags 0.
REQ-034 bit4 edge in IDLE, second edge 3 cycles later -> instant_reset_out high 8 cycles total; bit1=1 meanwhile -> trigger_out 0 throughout.
REQ-035 peripheral_reset pulsed 1 cycle in FAULT with instant_reset_out=1 -> next cycle all outputs 0, ctrl_sts=0.
REQ-036 bit3 edge on the cycle an ack timeout fires -> state FAULT, ack_fault=1.
